// File: rtl/maxpool2x2_seq_pkg.sv
// Shared definitions for the 2x2 max-pooling sequencer: default geometry,
// pooled dimensions and the sequencer state encoding.
package maxpool2x2_seq_pkg;

  localparam int unsigned W1_DEF    = 9;
  localparam int unsigned IMG_W_DEF = 26;
  localparam int unsigned IMG_H_DEF = 26;
  localparam int unsigned POOL_W    = IMG_W_DEF / 2;
  localparam int unsigned POOL_H    = IMG_H_DEF / 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StPool  = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/maxpool2x2_seq_if.sv
// Pixel-in / pooled-out stream bundle for maxpool2x2_seq.
//   in_data/in_valid/in_ready    : conv feature map, raster order
//   out_data/out_valid/out_ready : pooled map
//   out_last                     : marks the final pooled value of a frame
// master : environment side (pixel source, pooled-value sink)
// slave  : pooling block side
interface maxpool2x2_seq_if
  import maxpool2x2_seq_pkg::*;
#(
  parameter int w1 = W1_DEF
) ();

  logic signed [w1-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [w1-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/maxpool2x2_seq_max_4a.sv
// max_4a: combinational signed maximum of four samples.
//   num0..num3 : signed inputs
//   max_out    : largest of the four (ties return the shared value)
module max_4a #(
  parameter int w1 = 9
) (
  input  logic signed [w1-1:0] num0,
  input  logic signed [w1-1:0] num1,
  input  logic signed [w1-1:0] num2,
  input  logic signed [w1-1:0] num3,
  output logic signed [w1-1:0] max_out
);

  logic signed [w1-1:0] max01;
  logic signed [w1-1:0] max23;

  always_comb begin
    max01   = (num0 > num1) ? num0 : num1;
    max23   = (num2 > num3) ? num2 : num3;
    max_out = (max01 > max23) ? max01 : max23;
  end

endmodule

// File: rtl/maxpool2x2_seq.sv
// maxpool2x2_seq: 2x2 max-pooling sequencer between conv and dense layers.
// Buffers each even row in a line buffer; on the following odd row every
// second pixel completes a 2x2 window that is reduced by max_4a and
// registered onto the output stream.
//   clk, rst : clock and asynchronous active-high reset
//   start    : begin a frame (only honoured while idle)
//   busy     : high while a frame is in progress
//   done     : one-cycle pulse after the last pooled value is consumed
//   bus      : pixel-in / pooled-out streams (slave modport)
module maxpool2x2_seq
  import maxpool2x2_seq_pkg::*;
#(
  parameter int w1    = W1_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  maxpool2x2_seq_if.slave        bus
);

  localparam int ColW = $clog2(IMG_W);
  localparam int RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
    $fatal(1, "maxpool2x2_seq: IMG_W and IMG_H must be even and >= 2");
  end

  state_e               state_q, state_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [RowW-1:0]      row_q, row_d;
  logic signed [w1-1:0] prev_q, prev_d;
  logic signed [w1-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;

  logic signed [w1-1:0] linebuf_q [IMG_W];

  logic                 in_ready;
  logic                 out_fire;
  logic                 lb_we;
  logic [ColW-1:0]      col_even;
  logic signed [w1-1:0] win_max;

  // Left column of the current window (col is odd when the result is used).
  assign col_even = col_q & ~ColW'(1);

  max_4a #(
    .w1 (w1)
  ) u_max_4a (
    .num0    (linebuf_q[col_even]),
    .num1    (linebuf_q[col_q]),
    .num2    (prev_q),
    .num3    (bus.in_data),
    .max_out (win_max)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    prev_d      = prev_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    lb_we       = 1'b0;

    out_fire = out_valid_q && bus.out_ready;
    // Drain first; a reload in the same cycle below overrides it.
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          col_d   = '0;
          row_d   = '0;
        end
      end

      StFill: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          lb_we = 1'b1;
          if (col_q == ColLast) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = StPool;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      StPool: begin
        // Only accept when the output register can take a result.
        in_ready = !out_valid_q || bus.out_ready;
        if (bus.in_valid && in_ready) begin
          if (!col_q[0]) begin
            prev_d = bus.in_data;
          end else begin
            out_data_d  = win_max;
            out_valid_d = 1'b1;
            out_last_d  = (row_q == RowLast) && (col_q == ColLast);
          end
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = StDrain;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = StFill;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      StDrain: begin
        if (out_fire) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      prev_q      <= prev_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Line buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[col_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule
